// File: rtl/pc_next_unit.sv
//------------------------------------------------------------------------------
// pc_next_unit
//   Program-counter register and next-PC generator for the single-cycle RV32I
//   core. Forms the jump target from base_in + imm, selects the next PC
//   (PC+4 / target / hold / trap vector), tracks BOOT/RUN/HALT/TRAP state and
//   counts retired instructions.
//
//   Optional feature macro: PC_MISALIGN_TRAP_EN
//     defined   : a jump whose target has bit 1 set traps to TRAP_VEC for one
//                 cycle, recording the faulting PC in trap_pc.
//     undefined : targets are loaded as computed; trap and trap_pc read 0.
//
//   Ports:
//     clk       in   core clock, rising-edge
//     rst_n     in   synchronous active-low reset
//     stall     in   hold PC (instruction memory not ready)
//     halt_req  in   ebreak/halt decode
//     jump_en   in   JAL/JALR/taken-branch redirect
//     is_jalr   in   clear bit 0 of computed target
//     base_in   in   [31:0] jump base (PC or rs1)
//     imm       in   [31:0] sign-extended immediate
//     pc_out    out  [31:0] current fetch PC
//     pc_plus4  out  [31:0] pc_out + 4 (combinational)
//     pc_valid  out  fetch address valid
//     halted    out  core in HALT
//     trap      out  one-cycle misaligned-target pulse
//     trap_pc   out  [31:0] PC of the faulting jump
//     instret   out  [31:0] retired-instruction counter
//------------------------------------------------------------------------------
module pc_next_unit #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        halt_req,
   input  logic        jump_en,
   input  logic        is_jalr,
   input  logic [31:0] base_in,
   input  logic [31:0] imm,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        pc_valid,
   output logic        halted,
   output logic        trap,
   output logic [31:0] trap_pc,
   output logic [31:0] instret
);

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
`ifdef PC_MISALIGN_TRAP_EN
      S_TRAP,
`endif
      S_HALT
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instret_q, instret_d;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;
   logic [31:0] target;

`ifdef PC_MISALIGN_TRAP_EN
   logic        trap_q, trap_d;
   logic [31:0] trap_pc_q, trap_pc_d;
`endif

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      target = base_in + imm;
      if (is_jalr) begin
         target[0] = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instret_d = instret_q;
`ifdef PC_MISALIGN_TRAP_EN
      trap_pc_d = trap_pc_q;
`endif
      unique case (state_q)
         S_BOOT: state_d = S_RUN;
         S_RUN: begin
            if (halt_req) begin
               state_d   = S_HALT;
               instret_d = instret_q + 32'd1;
            end else if (stall) begin
               // jump_en deliberately ignored: the held instruction re-issues it
               state_d = S_RUN;
            end else if (jump_en) begin
`ifdef PC_MISALIGN_TRAP_EN
               if (target[1]) begin
                  trap_pc_d = pc_q;
                  pc_d      = TRAP_VEC;
                  state_d   = S_TRAP;
               end else begin
                  pc_d      = target;
                  instret_d = instret_q + 32'd1;
               end
`else
               pc_d      = target;
               instret_d = instret_q + 32'd1;
`endif
            end else begin
               pc_d      = pc_plus4;
               instret_d = instret_q + 32'd1;
            end
         end
`ifdef PC_MISALIGN_TRAP_EN
         // Bubble cycle at TRAP_VEC; fetch resumes there on the RUN cycle.
         S_TRAP: state_d = S_RUN;
`endif
         S_HALT: state_d = S_HALT;
         default: state_d = S_BOOT;
      endcase
   end

   // Flag outputs are registered from the next state so they line up with it.
   always_comb begin
      valid_d  = (state_d == S_RUN);
      halted_d = (state_d == S_HALT);
`ifdef PC_MISALIGN_TRAP_EN
      trap_d   = (state_d == S_TRAP);
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_BOOT;
         pc_q      <= RESET_VEC;
         instret_q <= '0;
         valid_q   <= 1'b0;
         halted_q  <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
         trap_q    <= 1'b0;
         trap_pc_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instret_q <= instret_d;
         valid_q   <= valid_d;
         halted_q  <= halted_d;
`ifdef PC_MISALIGN_TRAP_EN
         trap_q    <= trap_d;
         trap_pc_q <= trap_pc_d;
`endif
      end
   end

   assign pc_out   = pc_q;
   assign instret  = instret_q;
   assign pc_valid = valid_q;
   assign halted   = halted_q;

`ifdef PC_MISALIGN_TRAP_EN
   assign trap     = trap_q;
   assign trap_pc  = trap_pc_q;
`else
   logic unused_trap_vec;
   assign unused_trap_vec = ^TRAP_VEC;
   assign trap     = 1'b0;
   assign trap_pc  = '0;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

   localparam logic [31:0] RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n, stall, halt_req, jump_en, is_jalr;
   logic [31:0] base_in, imm;
   logic [31:0] pc_out, pc_plus4, trap_pc, instret;
   logic        pc_valid, halted, trap;

   pc_next_unit #(.RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .halt_req(halt_req),
      .jump_en(jump_en), .is_jalr(is_jalr), .base_in(base_in), .imm(imm),
      .pc_out(pc_out), .pc_plus4(pc_plus4), .pc_valid(pc_valid),
      .halted(halted), .trap(trap), .trap_pc(trap_pc), .instret(instret)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // Reference model: architectural view (PC, counter, mode flags).
   logic [31:0] m_pc, m_instret, m_trap_pc;
   bit          m_boot, m_halt, m_trap;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      logic [31:0] t;
      if (!rst_n) begin
         m_pc = RESET_VEC; m_boot = 1; m_halt = 0; m_trap = 0;
         m_trap_pc = '0; m_instret = '0;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (m_halt) begin
         // frozen until reset
      end else if (m_trap) begin
         m_trap = 0;
      end else if (halt_req) begin
         m_halt = 1; m_instret = m_instret + 1;
      end else if (stall) begin
         // nothing moves
      end else if (jump_en) begin
         t = base_in + imm;
         if (is_jalr) t = t & 32'hFFFF_FFFE;
`ifdef PC_MISALIGN_TRAP_EN
         if ((t % 4) >= 2) begin
            m_trap_pc = m_pc; m_pc = TRAP_VEC; m_trap = 1;
         end else begin
            m_pc = t; m_instret = m_instret + 1;
         end
`else
         m_pc = t; m_instret = m_instret + 1;
`endif
      end else begin
         m_pc = m_pc + 4; m_instret = m_instret + 1;
      end
   endtask

   task automatic check_all();
      chk("pc_out",   pc_out,   m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("pc_valid", {31'd0, pc_valid}, {31'd0, !(m_boot || m_halt || m_trap)});
      chk("halted",   {31'd0, halted},   {31'd0, m_halt});
      chk("trap",     {31'd0, trap},     {31'd0, m_trap});
      chk("trap_pc",  trap_pc,  m_trap_pc);
      chk("instret",  instret,  m_instret);
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      rst_n = 1; stall = 0; halt_req = 0; jump_en = 0; is_jalr = 0;
      base_in = '0; imm = '0;
   endtask

   task automatic goto_pc(input logic [31:0] a);
      idle_inputs();
      jump_en = 1; base_in = a; imm = '0;
      step();
      jump_en = 0;
   endtask

   initial begin
      idle_inputs();
      m_pc = '0; m_instret = '0; m_trap_pc = '0; m_boot = 1; m_halt = 0; m_trap = 0;
      #2;
      // reset, boot, sequential fetch
      rst_n = 0; step(); step();
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_valid", {31'd0, pc_valid}, 32'd0);
      rst_n = 1; step();
      chk("boot_valid", {31'd0, pc_valid}, 32'd1);
      chk("boot_pc", pc_out, 32'h0);
      step(); step(); step();
      chk("seq_pc", pc_out, 32'hC);
      chk("seq_instret", instret, 32'd3);

      // jumps: negative offset and JALR bit-0 clear
      goto_pc(32'h20);
      jump_en = 1; base_in = 32'h20; imm = 32'hFFFF_FFF0; step();
      chk("jmp_neg", pc_out, 32'h10);
      is_jalr = 1; base_in = 32'h1001; imm = '0; step();
      chk("jalr", pc_out, 32'h1000);
      is_jalr = 0; jump_en = 0;

      // stall dominates jump
      goto_pc(32'h40);
      stall = 1; jump_en = 1; base_in = 32'h80; imm = '0;
      repeat (3) step();
      chk("stall_pc", pc_out, 32'h40);
      stall = 0; step();
      chk("stall_rel", pc_out, 32'h80);
      jump_en = 0;

      // halt, frozen under toggling inputs, exit by reset
      goto_pc(32'h50);
      halt_req = 1; step();
      chk("halt_flag", {31'd0, halted}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         stall = 1'($urandom); halt_req = 1'($urandom); jump_en = 1'($urandom);
         is_jalr = 1'($urandom); base_in = $urandom; imm = $urandom;
         step();
      end
      chk("halt_pc", pc_out, 32'h50);
      idle_inputs(); rst_n = 0; step();
      chk("halt_rst_pc", pc_out, 32'h0);
      chk("halt_rst_flag", {31'd0, halted}, 32'd0);
      rst_n = 1; step();

      // misaligned target
      goto_pc(32'h60);
      jump_en = 1; base_in = 32'h60; imm = 32'd2; step();
      jump_en = 0;
`ifdef PC_MISALIGN_TRAP_EN
      chk("mis_trap", {31'd0, trap}, 32'd1);
      chk("mis_trap_pc", trap_pc, 32'h60);
      chk("mis_pc", pc_out, 32'h100);
      step(); step();
      chk("mis_after", pc_out, 32'h104);
      chk("mis_trap_off", {31'd0, trap}, 32'd0);
`else
      chk("mis_pc", pc_out, 32'h62);
      chk("mis_trap", {31'd0, trap}, 32'd0);
      step();
`endif

      // PC wrap and instret wrap
      goto_pc(32'hFFFF_FFFC);
      chk("pc4_wrap", pc_plus4, 32'h0);
      step();
      chk("pc_wrap", pc_out, 32'h0);
      force dut.instret_q = 32'hFFFF_FFFE;
      #1;
      release dut.instret_q;
      m_instret = 32'hFFFF_FFFE;
      step(); step();
      chk("instret_wrap", instret, 32'h0);

      // randomized phase
      for (int i = 0; i < 600; i++) begin
         rst_n    = !($urandom_range(0, 59) == 0) && !(m_halt && $urandom_range(0, 5) == 0);
         halt_req = ($urandom_range(0, 39) == 0);
         stall    = ($urandom_range(0, 3) == 0);
         jump_en  = 1'($urandom);
         is_jalr  = 1'($urandom);
         base_in  = ($urandom_range(0, 1) == 0) ? $urandom : {$urandom_range(0, 4095), 2'b00};
         imm      = 32'($signed($urandom_range(0, 63)) - 32);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter register and next-PC generator for the single-cycle RV32I core.
- Takes the jump base (PC or rs1, chosen by the upstream base-select mux) plus the immediate, and forms the jump target.
- Picks the next PC from PC+4, jump target, hold or trap vector, and drives the fetch address.
- Tracks boot/run/halt/trap state and counts retired instructions.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on misaligned-target trap (used only with the optional feature).

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- stall  in  1  hold PC this cycle (instruction memory not ready)
- halt_req  in  1  ebreak/halt decode; enter HALT
- jump_en  in  1  JAL/JALR/taken-branch redirect
- is_jalr  in  1  clear bit 0 of computed target
- base_in  in  32  jump base from the PC/rs1 select mux
- imm  in  32  sign-extended immediate
- pc_out  out  32  current fetch PC
- pc_plus4  out  32  pc_out+4, combinational, for rd writeback of JAL/JALR
- pc_valid  out  1  fetch address is valid
- halted  out  1  core is in HALT
- trap  out  1  one-cycle misaligned-target pulse
- trap_pc  out  32  PC of the faulting jump
- instret  out  32  retired-instruction counter

Behaviour:
- Reset is synchronous: rst_n=0 sampled at a rising edge.
  - pc_out=RESET_VEC, state=BOOT, pc_valid=0, halted=0, trap=0, trap_pc=0, instret=0.
  - Reset has priority over every other input in every state, including mid-HALT and mid-TRAP.
- target = base_in + imm, modulo 2^32, carry discarded. If is_jalr=1, target[0] is forced to 0.
- pc_plus4 = pc_out + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- States: BOOT, RUN, HALT, TRAP.
- BOOT:
  - Next cycle goes to RUN with pc_valid=1.
  - pc_out holds. All inputs are ignored.
- RUN, evaluated per cycle in priority order:
  1. halt_req=1: go to HALT; pc_out holds; pc_valid=0; halted=1; instret+1 (ebreak retires).
  2. stall=1: pc_out holds; instret holds; jump_en is ignored (the jump is re-evaluated next cycle from the same held instruction).
  3. jump_en=1:
     - Misaligned target (target[1]=1) with the feature enabled: see Optional Feature.
     - Otherwise pc_out<=target; instret+1.
  4. Otherwise: pc_out<=pc_plus4; instret+1.
- HALT:
  - pc_out, instret and trap_pc hold; pc_valid=0; halted=1.
  - Exit is by reset only.
- TRAP:
  - Lasts one cycle with pc_out=TRAP_VEC and trap=1.
  - Next state is RUN; trap deasserts.
- instret is a free-running 32-bit count that wraps from 32'hFFFF_FFFF to 0.
- All outputs are registered except pc_plus4.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - In RUN with jump_en=1, stall=0, halt_req=0 and target[1]=1: trap_pc<=pc_out, pc_out<=TRAP_VEC, state<=TRAP, trap<=1 for exactly one cycle.
  - instret does not increment for the faulting jump.
- Undefined:
  - target is loaded as computed, regardless of bit 1.
  - trap is tied to 0, trap_pc is tied to 0, and the TRAP state is not present.

Test Plan:
- rst_n=0 for 2 cycles, then 1 -> pc_out=0, pc_valid=0 for the BOOT cycle, then pc_valid=1. Next 3 cycles pc_out=4, 8, 12; instret=3.
- In RUN at pc=0x20: jump_en=1, base_in=0x20, imm=32'hFFFF_FFF0 -> pc_out=0x10. Then jump_en=1, is_jalr=1, base_in=0x1001, imm=0 -> pc_out=0x1000.
- stall=1 together with jump_en=1 for 3 cycles at pc=0x40 -> pc_out stays 0x40 and instret is unchanged. Release stall with jump_en held and target 0x80 -> pc_out=0x80.
- halt_req=1 at pc=0x50 -> halted=1, pc_valid=0, pc_out=0x50 held for 10 cycles with all inputs toggling. rst_n=0 -> pc_out=0, halted=0.
- With PC_MISALIGN_TRAP_EN at pc=0x60: jump_en=1, base_in=0x60, imm=2 -> trap=1 for one cycle, trap_pc=0x60, pc_out=0x100, then 0x104. Without the macro -> pc_out=0x62 and trap stays 0.
- pc_out=32'hFFFF_FFFC with no jump -> pc_out wraps to 0; instret preset near 32'hFFFF_FFFF wraps to 0.
